// File: rtl/uart_msg_pkg.sv
// Shared types, constants and helpers for the UART message frame controller.
package uart_msg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_LINE    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CSUM    = 3'd4;

    // Byte-lane mask of the final beat, indexed by LEN mod 4 (MSB-aligned lanes).
    function automatic logic [3:0] keep_from_rem(input logic [1:0] rem);
        logic [3:0] k;
        case (rem)
            2'd1:    k = 4'b1000;
            2'd2:    k = 4'b1100;
            2'd3:    k = 4'b1110;
            default: k = 4'b1111;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/uart_msg_ctrl.sv
// Frame controller behind the UART receiver: parses SYNC/LEN/payload frames and
// packs the payload big-endian into 32-bit AXI-Stream beats. Bad LEN, line
// errors and inter-byte timeouts abort the frame; a terminator beat closes any
// message that already produced a beat.
// Optional build macro UART_MSG_CTRL_CHECKSUM_EN adds a trailing XOR checksum
// byte (state CHK) that decides tuser of the final beat.
module uart_msg_ctrl
    import uart_msg_pkg::*;
#(
    parameter int MAX_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        rx_frame_error,
    input  logic        rx_overrun_error,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        err_valid,
    output logic [2:0]  err_code
);
    localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_acc, w_acc_ins;
    logic [1:0]  r_lane, r_lenm;
    logic [7:0]  r_rem;
    logic [19:0] r_timer;
    logic        r_rdy_en, r_word_full, r_word_last, r_word_user;
    logic [3:0]  r_word_keep;
    logic        r_emitted, r_term_pend;
    logic [31:0] r_out_data;
    logic [3:0]  r_out_keep;
    logic        r_out_last, r_out_user, r_out_valid;
    logic        r_err_valid;
    logic [2:0]  r_err_code;
`ifdef UART_MSG_CTRL_CHECKSUM_EN
    logic [7:0]  r_xor;
`endif

    logic        w_line_err, w_accept, w_byte_ok, w_in_frame, w_timeout;
    logic        w_abort, w_len_err, w_csum_err;
    logic [2:0]  w_abort_code;
    logic        w_new_done, w_new_last, w_new_user;
    logic [31:0] w_new_data;
    logic [3:0]  w_new_keep;
    logic        w_out_free, w_load_term, w_load_word, w_load_new, w_msg_load;

    // Handshake and event qualification; a line error always wins over a byte.
    assign s_axis_tready = r_rdy_en & ~r_word_full;
    assign w_line_err    = rx_frame_error | rx_overrun_error;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_byte_ok     = w_accept & ~w_line_err;
    assign w_in_frame    = (r_state != IDLE);
    assign w_timeout     = w_in_frame & s_axis_tready & ~w_accept & (r_timer == TIMER_LAST);

    // Output register source priority: queued terminator, waiting word, fresh word.
    assign w_out_free  = ~r_out_valid | m_axis_tready;
    assign w_load_term = w_out_free & r_term_pend;
    assign w_load_word = w_out_free & ~r_term_pend & r_word_full;
    assign w_load_new  = w_out_free & ~r_term_pend & ~r_word_full & w_new_done;
    assign w_msg_load  = w_load_word | w_load_new;

    // Insert the incoming byte at the current lane; lane 0 starts a fresh word.
    always_comb begin
        w_acc_ins = (r_lane == 2'd0) ? 32'h0 : r_acc;
        case (r_lane)
            2'd0:    w_acc_ins[31:24] = s_axis_tdata;
            2'd1:    w_acc_ins[23:16] = s_axis_tdata;
            2'd2:    w_acc_ins[15:8]  = s_axis_tdata;
            default: w_acc_ins[7:0]   = s_axis_tdata;
        endcase
    end

    // Next-state logic plus abort, error and word-completion strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_abort      = 1'b0;
        w_abort_code = ERR_LINE;
        w_len_err    = 1'b0;
        w_csum_err   = 1'b0;
        w_new_done   = 1'b0;
        w_new_data   = w_acc_ins;
        w_new_keep   = 4'b1111;
        w_new_last   = 1'b0;
        w_new_user   = 1'b0;
        if (w_in_frame && (w_line_err || w_timeout)) begin
            w_abort      = 1'b1;
            w_abort_code = w_line_err ? ERR_LINE : ERR_TIMEOUT;
            w_state_nxt  = IDLE;
        end else if (w_byte_ok) begin
            case (r_state)
                IDLE: begin
                    if (s_axis_tdata == SYNC_BYTE) w_state_nxt = LEN;
                end
                LEN: begin
                    if (s_axis_tdata == 8'd0 || s_axis_tdata > MAX_LEN_B) begin
                        w_len_err   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (r_rem == 8'd1) begin
`ifdef UART_MSG_CTRL_CHECKSUM_EN
                        w_state_nxt = CHK;
`else
                        w_new_done  = 1'b1;
                        w_new_keep  = keep_from_rem(r_lenm);
                        w_new_last  = 1'b1;
                        w_state_nxt = IDLE;
`endif
                    end else if (r_lane == 2'd3) begin
                        w_new_done = 1'b1;
                    end
                end
`ifdef UART_MSG_CTRL_CHECKSUM_EN
                CHK: begin
                    w_new_done  = 1'b1;
                    w_new_data  = r_acc;
                    w_new_keep  = keep_from_rem(r_lenm);
                    w_new_last  = 1'b1;
                    w_new_user  = (s_axis_tdata != r_xor);
                    w_csum_err  = w_new_user;
                    w_state_nxt = IDLE;
                end
`endif
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Control: ready enable, inter-byte timer, terminator bookkeeping, error report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy_en    <= 1'b0;
            r_timer     <= '0;
            r_emitted   <= 1'b0;
            r_term_pend <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_rdy_en <= 1'b1;
            if (!w_in_frame || w_accept || w_abort) r_timer <= '0;
            else if (s_axis_tready)                 r_timer <= r_timer + 20'd1;
            if (w_byte_ok && r_state == IDLE) r_emitted <= 1'b0;
            else if (w_msg_load)              r_emitted <= 1'b1;
            if (w_load_term) r_term_pend <= 1'b0;
            if (w_abort && (r_emitted || w_msg_load)) r_term_pend <= 1'b1;
            r_err_valid <= w_abort | w_len_err | w_csum_err;
            if (w_abort)         r_err_code <= w_abort_code;
            else if (w_len_err)  r_err_code <= ERR_LEN;
            else if (w_csum_err) r_err_code <= ERR_CSUM;
        end
    end

    // Accumulator, lane index, remaining count and the completed-word slot.
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_acc       <= '0;
            r_lane      <= '0;
            r_rem       <= '0;
            r_lenm      <= '0;
            r_word_full <= 1'b0;
            r_word_keep <= '0;
            r_word_last <= 1'b0;
            r_word_user <= 1'b0;
        end else begin
            if (w_load_word) r_word_full <= 1'b0;
            if (w_new_done && !w_load_new) begin
                r_word_full <= 1'b1;
                r_acc       <= w_new_data;
                r_word_keep <= w_new_keep;
                r_word_last <= w_new_last;
                r_word_user <= w_new_user;
            end
            if (w_byte_ok) begin
                case (r_state)
                    LEN: begin
                        r_rem  <= s_axis_tdata;
                        r_lenm <= s_axis_tdata[1:0];
                        r_lane <= 2'd0;
                    end
                    DATA: begin
                        r_rem <= r_rem - 8'd1;
                        if (w_new_done) begin
                            r_lane <= 2'd0;
                        end else begin
                            r_acc  <= w_acc_ins;
                            r_lane <= r_lane + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef UART_MSG_CTRL_CHECKSUM_EN
    // Running XOR of the payload bytes, restarted when LEN is accepted.
    always_ff @(posedge clk) begin
        if (rst || (w_byte_ok && r_state == LEN)) r_xor <= '0;
        else if (w_byte_ok && r_state == DATA)    r_xor <= r_xor ^ s_axis_tdata;
    end
`endif

    // Output beat register; holds until accepted, terminator takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load_term) begin
            r_out_data  <= '0;
            r_out_keep  <= 4'b0000;
            r_out_last  <= 1'b1;
            r_out_user  <= 1'b1;
            r_out_valid <= 1'b1;
        end else if (w_load_word) begin
            r_out_data  <= r_acc;
            r_out_keep  <= r_word_keep;
            r_out_last  <= r_word_last;
            r_out_user  <= r_word_user;
            r_out_valid <= 1'b1;
        end else if (w_load_new) begin
            r_out_data  <= w_new_data;
            r_out_keep  <= w_new_keep;
            r_out_last  <= w_new_last;
            r_out_user  <= w_new_user;
            r_out_valid <= 1'b1;
        end else if (m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;
    assign m_axis_tvalid = r_out_valid;
    assign busy          = w_in_frame | r_out_valid | r_word_full | r_term_pend;
    assign err_valid     = r_err_valid;
    assign err_code      = r_err_code;

endmodule

// File: tb/tb_uart_msg_ctrl.sv
// Self-checking bench for uart_msg_ctrl: a table of framed messages with
// hand-computed beats and error codes, plus directed multi-cycle sequences.
// Honours UART_MSG_CTRL_CHECKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_msg_ctrl;
    localparam int MAX_LEN = 64;
    localparam int TMO     = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        rx_frame_error = 1'b0;
    logic        rx_overrun_error = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tuser, m_axis_tvalid;
    logic        m_ready = 1'b1;
    logic        busy, err_valid;
    logic [2:0]  err_code;

    uart_msg_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
        .rx_frame_error(rx_frame_error), .rx_overrun_error(rx_overrun_error),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_ready),
        .busy(busy), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    typedef struct packed {
        int          nb;
        logic [95:0] b;
        logic        hc;
        logic [7:0]  cs;
        int          nbt;
        beat_t       b0;
        beat_t       b1;
        int          ne;
        logic [2:0]  e0;
        logic [2:0]  e1;
    } vec_t;

    beat_t      beat_q[$];
    logic [2:0] err_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    // Record accepted beats and error pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_ready)
                beat_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
            if (err_valid) err_q.push_back(err_code);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "time limit");
    end

    function automatic beat_t mkb(input logic [31:0] d, input logic [3:0] k,
                                  input logic l, input logic u);
        beat_t r;
        r.d = d; r.k = k; r.l = l; r.u = u;
        return r;
    endfunction

    function automatic vec_t mkv(input int nb, input logic [95:0] b, input logic hc,
                                 input logic [7:0] cs, input int nbt, input beat_t b0,
                                 input beat_t b1, input int ne, input logic [2:0] e0,
                                 input logic [2:0] e1);
        vec_t v;
        v.nb = nb; v.b = b; v.hc = hc; v.cs = cs; v.nbt = nbt;
        v.b0 = b0; v.b1 = b1; v.ne = ne; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_%0h: got tready 0 for 100 cycles, want 1", b);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic expect_beat(input string nm, input beat_t exp);
        beat_t act;
        if (beat_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no beat, want %0h", nm, exp);
        end else begin
            act = beat_q.pop_front();
            chk(nm, 64'(act), 64'(exp));
        end
    endtask

    task automatic expect_err(input string nm, input logic [2:0] exp);
        logic [2:0] act;
        if (err_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no err pulse, want code %0d", nm, exp);
        end else begin
            act = err_q.pop_front();
            chk(nm, 64'(act), 64'(exp));
        end
    endtask

    task automatic expect_quiet(input string nm);
        chk({nm, "_nbeats"}, 64'(beat_q.size()), 64'd0);
        chk({nm, "_nerrs"}, 64'(err_q.size()), 64'd0);
        beat_q.delete();
        err_q.delete();
    endtask

    initial begin
        vec_t vec [6];

        vec[0] = mkv(6, {8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 48'h0}, 1'b1, 8'h22,
                     1, mkb(32'hDEADBEEF, 4'b1111, 1'b1, 1'b0), '0, 0, 3'd0, 3'd0);
        vec[1] = mkv(5, {8'h33, 8'hA5, 8'h00, 8'hA5, 8'h41, 56'h0}, 1'b0, 8'h00,
                     0, '0, '0, 2, 3'd1, 3'd1);
        vec[2] = mkv(3, {8'hA5, 8'h01, 8'h7F, 72'h0}, 1'b1, 8'h7F,
                     1, mkb(32'h7F000000, 4'b1000, 1'b1, 1'b0), '0, 0, 3'd0, 3'd0);
        vec[3] = mkv(5, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 56'h0}, 1'b1, 8'h00,
                     1, mkb(32'h11223300, 4'b1110, 1'b1, 1'b0), '0, 0, 3'd0, 3'd0);
        vec[4] = mkv(7, {8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 40'h0}, 1'b1, 8'h01,
                     2, mkb(32'h01020304, 4'b1111, 1'b0, 1'b0),
                     mkb(32'h05000000, 4'b1000, 1'b1, 1'b0), 0, 3'd0, 3'd0);
        vec[5] = mkv(5, {8'hA5, 8'hA5, 8'h02, 8'hAB, 8'hCD, 56'h0}, 1'b0, 8'h00,
                     0, '0, '0, 1, 3'd1, 3'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'({err_valid, err_code}), 64'd0);
        rst = 1'b0;
        idle(2);
        chk("idle_s_tready", 64'(s_axis_tready), 64'd1);

        // One-cycle latency from the last byte to m_axis_tvalid
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        chk("lat_before", 64'(m_axis_tvalid), 64'd0);
        send_byte(8'hEF);
`ifdef UART_MSG_CTRL_CHECKSUM_EN
        chk("lat_csum_hold", 64'(m_axis_tvalid), 64'd0);
        send_byte(8'h22);
`endif
        chk("lat_valid", 64'(m_axis_tvalid), 64'd1);
        chk("lat_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
            64'(mkb(32'hDEADBEEF, 4'b1111, 1'b1, 1'b0)));
        idle(3);
        expect_beat("lat_rx", mkb(32'hDEADBEEF, 4'b1111, 1'b1, 1'b0));
        expect_quiet("lat");

        // Table of framed messages
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vec[i].nb; j++) send_byte(vec[i].b[95-8*j -: 8]);
`ifdef UART_MSG_CTRL_CHECKSUM_EN
            if (vec[i].hc) send_byte(vec[i].cs);
`endif
            idle(8);
            chk($sformatf("v%0d_nbeats", i), 64'(beat_q.size()), 64'(vec[i].nbt));
            if (vec[i].nbt > 0) expect_beat($sformatf("v%0d_beat0", i), vec[i].b0);
            if (vec[i].nbt > 1) expect_beat($sformatf("v%0d_beat1", i), vec[i].b1);
            chk($sformatf("v%0d_nerrs", i), 64'(err_q.size()), 64'(vec[i].ne));
            if (vec[i].ne > 0) expect_err($sformatf("v%0d_err0", i), vec[i].e0);
            if (vec[i].ne > 1) expect_err($sformatf("v%0d_err1", i), vec[i].e1);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
            beat_q.delete();
            err_q.delete();
        end

        // Backpressure: second word waits, byte input stalls, nothing lost
        m_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h06);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
`ifdef UART_MSG_CTRL_CHECKSUM_EN
        send_byte(8'h07);
`endif
        chk("bp_s_tready", 64'(s_axis_tready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        idle(20);
        chk("bp_s_tready_hold", 64'(s_axis_tready), 64'd0);
        chk("bp_beat_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
            64'({1'b1, 32'h01020304, 4'b1111, 1'b0}));
        m_ready = 1'b1;
        idle(4);
        expect_beat("bp_beat0", mkb(32'h01020304, 4'b1111, 1'b0, 1'b0));
        expect_beat("bp_beat1", mkb(32'h05060000, 4'b1100, 1'b1, 1'b0));
        chk("bp_s_tready_after", 64'(s_axis_tready), 64'd1);
        expect_quiet("bp");

        // Line error after one emitted beat -> terminator
        send_byte(8'hA5); send_byte(8'h08);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        rx_frame_error = 1'b1;
        idle(1);
        rx_frame_error = 1'b0;
        idle(5);
        expect_beat("fe_beat0", mkb(32'h01020304, 4'b1111, 1'b0, 1'b0));
        expect_beat("fe_term", mkb(32'h0, 4'b0000, 1'b1, 1'b1));
        expect_err("fe_code", 3'd2);
        chk("fe_busy", 64'(busy), 64'd0);
        expect_quiet("fe");

        // Inter-byte timeout with no beat emitted, then a clean frame
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        for (int c = 0; c < TMO + 20 && err_q.size() == 0; c++) idle(1);
        expect_err("tmo_code", 3'd3);
        chk("tmo_busy", 64'(busy), 64'd0);
        expect_quiet("tmo");
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F);
`ifdef UART_MSG_CTRL_CHECKSUM_EN
        send_byte(8'h7F);
`endif
        idle(4);
        expect_beat("tmo_next", mkb(32'h7F000000, 4'b1000, 1'b1, 1'b0));
        expect_quiet("tmo_next");

        // Error in the same cycle as a byte; then a line error in IDLE is ignored
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        rx_overrun_error = 1'b1;
        send_byte(8'hBB);
        rx_overrun_error = 1'b0;
        idle(4);
        expect_err("sim_code", 3'd2);
        chk("sim_busy", 64'(busy), 64'd0);
        expect_quiet("sim");
        rx_frame_error = 1'b1;
        idle(1);
        rx_frame_error = 1'b0;
        idle(3);
        expect_quiet("idle_lerr");

`ifdef UART_MSG_CTRL_CHECKSUM_EN
        // Checksum match and mismatch
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hFF);
        idle(4);
        expect_beat("cs_ok", mkb(32'h0FF00000, 4'b1100, 1'b1, 1'b0));
        expect_quiet("cs_ok");
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h00);
        idle(4);
        expect_beat("cs_bad", mkb(32'h0FF00000, 4'b1100, 1'b1, 1'b1));
        expect_err("cs_bad_code", 3'd4);
        expect_quiet("cs_bad");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
